can_tx_scheduler: RTL and testbench

- Sequences transmit frames from the high-priority buffer (HPB) and the TX FIFO into the bit stream processor (BSP).
- Pops one frame, holds a local copy, hands it to the BSP with a send handshake, and watches the outcome flags.
- Retransmits on arbitration loss or bus error up to a limit, then aborts. Reports completion and abort to the config registers.
- Sits in the SYS_CLK domain between the config registers, tx_fifo and can_bsp.

---
 rtl/can_tx_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_can_tx_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: pops a frame from the HPB or TX FIFO, hands it to the BSP and tracks the outcome.
// Define CAN_TX_AUTO_RETX_EN to enable automatic retransmission; otherwise frames are sent single-shot.
module can_tx_scheduler #(
   parameter int unsigned FRAME_W      = 128,
   parameter int unsigned MAX_RETRY    = 8,
   parameter int unsigned SEND_TIMEOUT = 255
) (
   input  logic               i_sys_clk,
   input  logic               i_reset,
   input  logic               i_cen,
   input  logic               i_hpb_full,
   input  logic [FRAME_W-1:0] i_hpb_data,
   output logic               o_hpb_r_en,
   input  logic               i_tx_empty,
   input  logic [FRAME_W-1:0] i_fifo_data,
   output logic               o_fifo_r_en,
   input  logic               i_busy_can,
   input  logic               i_txok,
   input  logic               i_arblst,
   input  logic               i_error,
   input  logic               i_bsoff,
   output logic [FRAME_W-1:0] o_send_data,
   output logic               o_send_en,
   output logic               o_sched_busy,
   output logic               o_src_hpb,
   output logic [3:0]         o_retry_cnt,
   output logic               o_tx_done,
   output logic               o_abort
);

   localparam int unsigned RETRY_W = 4;
   localparam int unsigned TMO_W   = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SEND   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_RETRY  = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   state_e               state_q, state_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
   logic                 src_hpb_q, src_hpb_d;
   logic                 hpb_r_en_q, hpb_r_en_d;
   logic                 fifo_r_en_q, fifo_r_en_d;
   logic                 send_en_q, send_en_d;
   logic                 busy_q, busy_d;
   logic                 tx_done_q, tx_done_d;
   logic                 abort_q, abort_d;

   logic                 idle_ok_c;
   logic                 req_c;
   logic                 tmo_hit_c;
   logic                 send_abort_c;
   logic                 retry_abort_c;
   logic                 bsp_fail_c;

   assign idle_ok_c     = i_cen && !i_bsoff && !i_busy_can;
   assign req_c         = i_hpb_full || !i_tx_empty;
   assign tmo_hit_c     = (TMO_W'(tmo_q + TMO_W'(1)) == TMO_W'(SEND_TIMEOUT));
   assign send_abort_c  = !i_cen || i_bsoff || tmo_hit_c;
   assign retry_abort_c = (retry_cnt_q == RETRY_W'(MAX_RETRY)) || !i_cen;
   assign bsp_fail_c    = i_arblst || i_error;

   // State register
   always_ff @(posedge i_sys_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (idle_ok_c && req_c) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (send_abort_c)    state_d = ST_IDLE;
            else if (i_busy_can) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (i_bsoff)         state_d = ST_IDLE;
            else if (i_txok)     state_d = ST_DONE;
            else if (bsp_fail_c) begin
`ifdef CAN_TX_AUTO_RETX_EN
               state_d = ST_RETRY;
`else
               state_d = ST_IDLE;
`endif
            end
         end
         ST_RETRY: begin
            if (retry_abort_c)    state_d = ST_IDLE;
            else if (!i_busy_can) state_d = ST_SEND;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output and datapath next values; any exit to IDLE other than from DONE is an abort
   always_comb begin
      frame_d     = frame_q;
      tmo_d       = tmo_q;
      retry_cnt_d = retry_cnt_q;
      src_hpb_d   = src_hpb_q;
      hpb_r_en_d  = 1'b0;
      fifo_r_en_d = 1'b0;
      abort_d     = 1'b0;
      send_en_d   = (state_d == ST_SEND);
      tx_done_d   = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (state_d == ST_LOAD) begin
               src_hpb_d   = i_hpb_full;
               hpb_r_en_d  = i_hpb_full;
               fifo_r_en_d = !i_hpb_full;
               retry_cnt_d = '0;
            end
         end
         ST_LOAD: begin
            frame_d = src_hpb_q ? i_hpb_data : i_fifo_data;
            tmo_d   = '0;
         end
         ST_SEND: begin
            tmo_d = TMO_W'(tmo_q + TMO_W'(1));
            if (state_d == ST_IDLE) abort_d = 1'b1;
         end
         ST_ACTIVE: begin
            if (state_d == ST_IDLE) abort_d = 1'b1;
         end
         ST_RETRY: begin
            if (state_d == ST_IDLE) begin
               abort_d = 1'b1;
            end else if (state_d == ST_SEND) begin
               tmo_d       = '0;
               retry_cnt_d = (retry_cnt_q == '1) ? retry_cnt_q
                                                 : RETRY_W'(retry_cnt_q + RETRY_W'(1));
            end
         end
         default: begin
         end
      endcase
`ifdef CAN_TX_AUTO_RETX_EN
`else
      retry_cnt_d = '0;
`endif
   end

   // Registered outputs and frame copy
   always_ff @(posedge i_sys_clk or posedge i_reset) begin
      if (i_reset) begin
         frame_q     <= '0;
         tmo_q       <= '0;
         retry_cnt_q <= '0;
         src_hpb_q   <= 1'b0;
         hpb_r_en_q  <= 1'b0;
         fifo_r_en_q <= 1'b0;
         send_en_q   <= 1'b0;
         busy_q      <= 1'b0;
         tx_done_q   <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         frame_q     <= frame_d;
         tmo_q       <= tmo_d;
         retry_cnt_q <= retry_cnt_d;
         src_hpb_q   <= src_hpb_d;
         hpb_r_en_q  <= hpb_r_en_d;
         fifo_r_en_q <= fifo_r_en_d;
         send_en_q   <= send_en_d;
         busy_q      <= busy_d;
         tx_done_q   <= tx_done_d;
         abort_q     <= abort_d;
      end
   end

   assign o_send_data  = frame_q;
   assign o_send_en    = send_en_q;
   assign o_sched_busy = busy_q;
   assign o_src_hpb    = src_hpb_q;
   assign o_retry_cnt  = retry_cnt_q;
   assign o_hpb_r_en   = hpb_r_en_q;
   assign o_fifo_r_en  = fifo_r_en_q;
   assign o_tx_done    = tx_done_q;
   assign o_abort      = abort_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed self-checking bench for can_tx_scheduler (MAX_RETRY=3, SEND_TIMEOUT=10).
// Retry scenarios run when CAN_TX_AUTO_RETX_EN is defined, single-shot scenarios otherwise.
module tb_can_tx_scheduler;

   localparam int unsigned FW = 128;
   localparam int unsigned MR = 3;
   localparam int unsigned TO = 10;

   localparam logic [FW-1:0] FA = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
   localparam logic [FW-1:0] FB = 128'hB0B1_B2B3_B4B5_B6B7_B8B9_BABB_BCBD_BEBF;
   localparam logic [FW-1:0] FC = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [FW-1:0] FD = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

   logic          clk = 1'b0;
   logic          rst;
   logic          cen, hpb_full, tx_empty, busy_can, txok, arblst, err, bsoff;
   logic [FW-1:0] hpb_data, fifo_data;
   logic          hpb_r_en, fifo_r_en, send_en, sched_busy, src_hpb, tx_done, abort_o;
   logic [FW-1:0] send_data;
   logic [3:0]    retry_cnt;

   int total = 0;
   int bad   = 0;
   int n_hpb_pop = 0, n_fifo_pop = 0, n_send = 0, n_abort = 0;
   logic send_prev = 1'b0;
   int b_hpb, b_fifo, b_send, b_abort;

   always #5 clk = ~clk;

   can_tx_scheduler #(.FRAME_W(FW), .MAX_RETRY(MR), .SEND_TIMEOUT(TO)) dut (
      .i_sys_clk(clk), .i_reset(rst), .i_cen(cen),
      .i_hpb_full(hpb_full), .i_hpb_data(hpb_data), .o_hpb_r_en(hpb_r_en),
      .i_tx_empty(tx_empty), .i_fifo_data(fifo_data), .o_fifo_r_en(fifo_r_en),
      .i_busy_can(busy_can), .i_txok(txok), .i_arblst(arblst), .i_error(err),
      .i_bsoff(bsoff), .o_send_data(send_data), .o_send_en(send_en),
      .o_sched_busy(sched_busy), .o_src_hpb(src_hpb), .o_retry_cnt(retry_cnt),
      .o_tx_done(tx_done), .o_abort(abort_o)
   );

   // Pulse / handshake counters
   always @(negedge clk) begin
      if (hpb_r_en)            n_hpb_pop++;
      if (fifo_r_en)           n_fifo_pop++;
      if (abort_o)             n_abort++;
      if (send_en && !send_prev) n_send++;
      send_prev = send_en;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet;
      cen = 1'b1; hpb_full = 1'b0; tx_empty = 1'b1; busy_can = 1'b0;
      txok = 1'b0; arblst = 1'b0; err = 1'b0; bsoff = 1'b0;
   endtask

   task automatic snap;
      b_hpb = n_hpb_pop; b_fifo = n_fifo_pop; b_send = n_send; b_abort = n_abort;
   endtask

   // Drive an ACTIVE frame through to a successful completion and back to IDLE
   task automatic finish_ok;
      busy_can = 1'b1; tick;
      txok = 1'b1; tick;
      txok = 1'b0; busy_can = 1'b0; tick;
   endtask

   task automatic test_reset;
      rst = 1'b1; quiet; hpb_data = '0; fifo_data = '0;
      tick; tick;
      total++; if (send_en !== 1'b0) begin bad++; $display("FAIL reset_send_en got=%b exp=0", send_en); end
      total++; if (send_data !== '0) begin bad++; $display("FAIL reset_send_data got=%h exp=0", send_data); end
      total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", sched_busy); end
      total++; if ({hpb_r_en, fifo_r_en, src_hpb, tx_done, abort_o, retry_cnt} !== 9'h0) begin
         bad++; $display("FAIL reset_misc got=%h exp=0", {hpb_r_en, fifo_r_en, src_hpb, tx_done, abort_o, retry_cnt});
      end
      rst = 1'b0; tick;
      total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b exp=0", sched_busy); end
   endtask

   task automatic test_priority;
      quiet; snap;
      hpb_full = 1'b1; hpb_data = FA; tx_empty = 1'b0; fifo_data = FB;
      tick; // LOAD
      total++; if ({hpb_r_en, fifo_r_en, src_hpb, send_en} !== 4'b1010) begin
         bad++; $display("FAIL prio_load got=%b exp=1010", {hpb_r_en, fifo_r_en, src_hpb, send_en});
      end
      tick; // SEND
      total++; if ({send_en, hpb_r_en, fifo_r_en} !== 3'b100) begin
         bad++; $display("FAIL prio_send got=%b exp=100", {send_en, hpb_r_en, fifo_r_en});
      end
      total++; if (send_data !== FA) begin bad++; $display("FAIL prio_data got=%h exp=%h", send_data, FA); end
      hpb_full = 1'b0; busy_can = 1'b1;
      tick; // ACTIVE
      total++; if ({send_en, sched_busy} !== 2'b01) begin
         bad++; $display("FAIL prio_active got=%b exp=01", {send_en, sched_busy});
      end
      txok = 1'b1; tick; // DONE
      total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL prio_done got=%b exp=1", tx_done); end
      total++; if (n_fifo_pop - b_fifo !== 0) begin bad++; $display("FAIL prio_no_fifo got=%0d exp=0", n_fifo_pop - b_fifo); end
      txok = 1'b0; busy_can = 1'b0;
      tick; // IDLE
      total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL prio_done_pulse got=%b exp=0", tx_done); end
      tick; // LOAD from FIFO
      total++; if ({fifo_r_en, hpb_r_en, src_hpb} !== 3'b100) begin
         bad++; $display("FAIL prio_fifo_load got=%b exp=100", {fifo_r_en, hpb_r_en, src_hpb});
      end
      tick; // SEND
      tx_empty = 1'b1;
      total++; if (send_data !== FB || send_en !== 1'b1) begin
         bad++; $display("FAIL prio_fifo_send got=%h/%b exp=%h/1", send_data, send_en, FB);
      end
      finish_ok;
      total++; if (send_data !== FB) begin bad++; $display("FAIL data_hold got=%h exp=%h", send_data, FB); end
      total++; if (n_hpb_pop - b_hpb !== 1 || n_fifo_pop - b_fifo !== 1) begin
         bad++; $display("FAIL prio_pops got=%0d/%0d exp=1/1", n_hpb_pop - b_hpb, n_fifo_pop - b_fifo);
      end
   endtask

`ifdef CAN_TX_AUTO_RETX_EN
   task automatic test_retry;
      quiet; snap;
      tx_empty = 1'b0; fifo_data = FC;
      tick; tick; // LOAD, SEND
      tx_empty = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         busy_can = 1'b1; tick;
         arblst = 1'b1; tick; // RETRY
         arblst = 1'b0; busy_can = 1'b0; tick; // SEND again
         total++; if (retry_cnt !== 4'(k) || send_en !== 1'b1) begin
            bad++; $display("FAIL retry_step%0d got=%0d/%b exp=%0d/1", k, retry_cnt, send_en, k);
         end
      end
      busy_can = 1'b1; tick;
      txok = 1'b1; tick;
      total++; if (tx_done !== 1'b1 || retry_cnt !== 4'd3) begin
         bad++; $display("FAIL retry_done got=%b/%0d exp=1/3", tx_done, retry_cnt);
      end
      txok = 1'b0; busy_can = 1'b0; tick;
      total++; if (n_fifo_pop - b_fifo !== 1 || n_send - b_send !== 4) begin
         bad++; $display("FAIL retry_counts pops=%0d sends=%0d exp=1/4", n_fifo_pop - b_fifo, n_send - b_send);
      end
   endtask

   task automatic test_retry_limit;
      quiet; snap;
      hpb_full = 1'b1; hpb_data = FD;
      tick; tick;
      hpb_full = 1'b0;
      for (int k = 0; k <= 3; k++) begin
         busy_can = 1'b1; tick;
         err = 1'b1; tick;
         err = 1'b0; busy_can = 1'b0; tick;
         if (k < 3) begin
            total++; if (retry_cnt !== 4'(k + 1) || send_en !== 1'b1) begin
               bad++; $display("FAIL limit_step%0d got=%0d/%b exp=%0d/1", k, retry_cnt, send_en, k + 1);
            end
         end else begin
            total++; if ({abort_o, sched_busy} !== 2'b10 || retry_cnt !== 4'd3) begin
               bad++; $display("FAIL limit_abort got=%b/%0d exp=10/3", {abort_o, sched_busy}, retry_cnt);
            end
         end
      end
      tick;
      total++; if (n_send - b_send !== 4 || n_abort - b_abort !== 1) begin
         bad++; $display("FAIL limit_counts sends=%0d aborts=%0d exp=4/1", n_send - b_send, n_abort - b_abort);
      end
   endtask
`else
   task automatic test_single_shot;
      quiet; snap;
      tx_empty = 1'b0; fifo_data = FC;
      tick; tick;
      tx_empty = 1'b1; busy_can = 1'b1;
      tick; // ACTIVE
      arblst = 1'b1; tick;
      total++; if ({abort_o, sched_busy, tx_done} !== 3'b100 || retry_cnt !== 4'd0) begin
         bad++; $display("FAIL ss_arb got=%b/%0d exp=100/0", {abort_o, sched_busy, tx_done}, retry_cnt);
      end
      arblst = 1'b0; busy_can = 1'b0; tick;
      total++; if (abort_o !== 1'b0) begin bad++; $display("FAIL ss_abort_pulse got=%b exp=0", abort_o); end
      hpb_full = 1'b1; hpb_data = FD;
      tick; tick;
      hpb_full = 1'b0; busy_can = 1'b1;
      tick;
      err = 1'b1; tick;
      total++; if ({abort_o, sched_busy} !== 2'b10 || retry_cnt !== 4'd0) begin
         bad++; $display("FAIL ss_err got=%b/%0d exp=10/0", {abort_o, sched_busy}, retry_cnt);
      end
      err = 1'b0; busy_can = 1'b0; tick; tick;
      total++; if (n_send - b_send !== 2 || n_abort - b_abort !== 2) begin
         bad++; $display("FAIL ss_counts sends=%0d aborts=%0d exp=2/2", n_send - b_send, n_abort - b_abort);
      end
   endtask
`endif

   task automatic test_timeout;
      bit hold_ok;
      quiet; snap;
      hpb_full = 1'b1; hpb_data = FA;
      tick; tick; // SEND
      hpb_full = 1'b0;
      hold_ok = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick;
         if (send_en !== 1'b1 || abort_o !== 1'b0) hold_ok = 1'b0;
      end
      total++; if (hold_ok !== 1'b1) begin bad++; $display("FAIL tmo_hold got=%b exp=1", hold_ok); end
      tick;
      total++; if ({send_en, abort_o, sched_busy} !== 3'b010) begin
         bad++; $display("FAIL tmo_abort got=%b exp=010", {send_en, abort_o, sched_busy});
      end
      tick;
   endtask

   task automatic test_coincide;
      quiet;
      tx_empty = 1'b0; fifo_data = FB;
      tick; tick;
      tx_empty = 1'b1; busy_can = 1'b1; tick;
      txok = 1'b1; err = 1'b1; tick;
      total++; if ({tx_done, abort_o} !== 2'b10 || retry_cnt !== 4'd0) begin
         bad++; $display("FAIL co_ok_err got=%b/%0d exp=10/0", {tx_done, abort_o}, retry_cnt);
      end
      txok = 1'b0; err = 1'b0; busy_can = 1'b0; tick;
      hpb_full = 1'b1; hpb_data = FC;
      tick; tick;
      hpb_full = 1'b0; busy_can = 1'b1; tick;
      bsoff = 1'b1; txok = 1'b1; tick;
      total++; if ({abort_o, tx_done, sched_busy} !== 3'b100) begin
         bad++; $display("FAIL co_bsoff got=%b exp=100", {abort_o, tx_done, sched_busy});
      end
      bsoff = 1'b0; txok = 1'b0; busy_can = 1'b0; tick;
      total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL co_no_done got=%b exp=0", tx_done); end
   endtask

   task automatic test_gating;
      quiet; snap;
      tx_empty = 1'b0; fifo_data = FD; bsoff = 1'b1;
      tick; tick; tick;
      bsoff = 1'b0; cen = 1'b0;
      tick; tick; tick;
      total++; if (n_fifo_pop - b_fifo !== 0 || sched_busy !== 1'b0) begin
         bad++; $display("FAIL gate_idle pops=%0d busy=%b exp=0/0", n_fifo_pop - b_fifo, sched_busy);
      end
      cen = 1'b1; tick;
      total++; if (fifo_r_en !== 1'b1) begin bad++; $display("FAIL gate_release got=%b exp=1", fifo_r_en); end
      tick; tx_empty = 1'b1;
      finish_ok;
   endtask

   task automatic test_preempt;
      quiet; snap;
      tx_empty = 1'b0; fifo_data = FB;
      tick; tick;
      tx_empty = 1'b1; busy_can = 1'b1; tick;
      hpb_full = 1'b1; hpb_data = FD;
      tick; tick;
      txok = 1'b1; tick;
      txok = 1'b0; busy_can = 1'b0; tick;
      total++; if (n_hpb_pop - b_hpb !== 0) begin bad++; $display("FAIL pre_wait got=%0d exp=0", n_hpb_pop - b_hpb); end
      tick;
      total++; if ({hpb_r_en, src_hpb} !== 2'b11) begin bad++; $display("FAIL pre_load got=%b exp=11", {hpb_r_en, src_hpb}); end
      tick;
      total++; if (send_data !== FD) begin bad++; $display("FAIL pre_data got=%h exp=%h", send_data, FD); end
      hpb_full = 1'b0;
      finish_ok;
   endtask

   task automatic test_reset_active;
      quiet;
      tx_empty = 1'b0; fifo_data = FC;
      tick; tick;
      tx_empty = 1'b1; busy_can = 1'b1; tick; // ACTIVE
      total++; if (sched_busy !== 1'b1) begin bad++; $display("FAIL rsta_pre got=%b exp=1", sched_busy); end
      #2 rst = 1'b1;
      #1;
      total++; if ({send_en, sched_busy, src_hpb, retry_cnt} !== 7'h0 || send_data !== '0) begin
         bad++; $display("FAIL rsta_async got=%h/%h exp=0/0", {send_en, sched_busy, src_hpb, retry_cnt}, send_data);
      end
      busy_can = 1'b0; tick; tick;
      snap;
      rst = 1'b0; tick; tick; tick;
      total++; if (n_abort - b_abort !== 0 || sched_busy !== 1'b0) begin
         bad++; $display("FAIL rsta_after aborts=%0d busy=%b exp=0/0", n_abort - b_abort, sched_busy);
      end
   endtask

   initial begin
      test_reset;
      test_priority;
`ifdef CAN_TX_AUTO_RETX_EN
      test_retry;
      test_retry_limit;
`else
      test_single_shot;
`endif
      test_timeout;
      test_coincide;
      test_gating;
      test_preempt;
      test_reset_active;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
